// File: rtl/regfile_pkg.sv
// Shared constants for the register-file select scheduler: logical ids,
// physical select bit positions, exchange encodings, FSM states, bank state.
package regfile_pkg;

  localparam int unsigned ID_W = 4;

  localparam logic [ID_W-1:0] ID_PC = 4'd0;
  localparam logic [ID_W-1:0] ID_IR = 4'd1;
  localparam logic [ID_W-1:0] ID_WZ = 4'd2;
  localparam logic [ID_W-1:0] ID_SP = 4'd3;
  localparam logic [ID_W-1:0] ID_IY = 4'd4;
  localparam logic [ID_W-1:0] ID_IX = 4'd5;
  localparam logic [ID_W-1:0] ID_HL = 4'd6;
  localparam logic [ID_W-1:0] ID_DE = 4'd7;
  localparam logic [ID_W-1:0] ID_BC = 4'd8;
  localparam logic [ID_W-1:0] ID_AF = 4'd9;

  // Bits below SEG_SPLIT belong to the left (address) segment.
  localparam int unsigned P_PC      = 0;
  localparam int unsigned P_IR      = 1;
  localparam int unsigned P_WZ      = 2;
  localparam int unsigned P_SP      = 3;
  localparam int unsigned P_IY      = 4;
  localparam int unsigned P_IX      = 5;
  localparam int unsigned P_HL1     = 6;
  localparam int unsigned P_HL0     = 7;
  localparam int unsigned P_DE1     = 8;
  localparam int unsigned P_DE0     = 9;
  localparam int unsigned P_BC1     = 10;
  localparam int unsigned P_BC0     = 11;
  localparam int unsigned P_AF1     = 12;
  localparam int unsigned P_AF0     = 13;
  localparam int unsigned SEG_SPLIT = 2;

  typedef enum logic [1:0] {
    EXCH_NONE = 2'b00,
    EXCH_AF   = 2'b01,
    EXCH_EXX  = 2'b10,
    EXCH_DEHL = 2'b11
  } exch_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_XFER_RD = 2'd1,
    S_XFER_WR = 2'd2
  } state_e;

  typedef struct packed {
    logic       af_bank;
    logic       exx_bank;
    logic [1:0] dehl_swap;
  } bank_t;

endpackage

// File: rtl/regfile_map.sv
// Logical register id to one-hot physical select, honouring the current
// AF/EXX bank and the per-bank DE/HL swap.
module regfile_map
  import regfile_pkg::*;
#(
  parameter int unsigned NREG = 14
) (
  input  logic [ID_W-1:0] id,
  input  bank_t           bank,
  output logic [NREG-1:0] sel_c,
  output logic            left_c,
  output logic            right_c,
  output logic            bad_c
);

  int unsigned phys;
  logic        hit;
  logic        swap;

  always_comb begin
    phys  = 0;
    hit   = 1'b1;
    swap  = bank.dehl_swap[bank.exx_bank];
    case (id)
      ID_PC:   phys = P_PC;
      ID_IR:   phys = P_IR;
      ID_WZ:   phys = P_WZ;
      ID_SP:   phys = P_SP;
      ID_IY:   phys = P_IY;
      ID_IX:   phys = P_IX;
      // DE/HL trade places when the active bank's swap bit is set
      ID_HL:   phys = (swap ^ bank.exx_bank) ? ((swap) ? P_DE1 : P_HL1)
                                             : ((swap) ? P_DE0 : P_HL0);
      ID_DE:   phys = (swap ^ bank.exx_bank) ? ((swap) ? P_HL1 : P_DE1)
                                             : ((swap) ? P_HL0 : P_DE0);
      ID_BC:   phys = bank.exx_bank ? P_BC1 : P_BC0;
      ID_AF:   phys = bank.af_bank  ? P_AF1 : P_AF0;
      default: hit  = 1'b0;
    endcase
    if (swap) begin
      if (id == ID_HL) phys = bank.exx_bank ? P_DE1 : P_DE0;
      if (id == ID_DE) phys = bank.exx_bank ? P_HL1 : P_HL0;
    end else begin
      if (id == ID_HL) phys = bank.exx_bank ? P_HL1 : P_HL0;
      if (id == ID_DE) phys = bank.exx_bank ? P_DE1 : P_DE0;
    end
    sel_c   = hit ? (NREG'(1) << phys) : '0;
    left_c  = hit && (phys < SEG_SPLIT);
    right_c = hit && (phys >= SEG_SPLIT);
    bad_c   = ~hit;
  end

endmodule

// File: rtl/regfile_scheduler.sv
// Arbitrates left/right register requests, register-to-register copies and
// bank exchanges onto the physical register selects; all outputs registered.
module regfile_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned NREG = 14
) (
  input  logic            eclk,
  input  logic            erst_n,
  input  logic            req_l,
  input  logic [ID_W-1:0] id_l,
  input  logic            wr_l,
  input  logic            req_r,
  input  logic [ID_W-1:0] id_r,
  input  logic            wr_r,
  input  logic            xfer_req,
  input  logic [ID_W-1:0] xfer_src,
  input  logic [ID_W-1:0] xfer_dst,
  input  logic [1:0]      exch,
  output logic [NREG-1:0] regsel,
  output logic            pc_wr,
  output logic            reg_wr,
  output logic            r_p,
  output logic            gnt_l,
  output logic            gnt_r,
  output logic            xfer_done,
  output logic            exch_ack,
  output logic            id_err
);

  state_e          state_q, state_d;
  bank_t           bank_q, bank_d;
  logic            rr_q, rr_d;
  logic [ID_W-1:0] xdst_q, xdst_d;

  logic [NREG-1:0] regsel_d;
  logic            pc_wr_d, reg_wr_d, r_p_d, gnt_l_d, gnt_r_d;
  logic            xfer_done_d, exch_ack_d, id_err_d;

  logic [NREG-1:0] sel_l_c, sel_r_c, sel_x_c;
  logic            left_l_c, right_l_c, bad_l_c;
  logic            left_r_c, right_r_c, bad_r_c;
  logic            left_x_c, right_x_c, bad_x_c;
  logic [ID_W-1:0] xid_c;
  logic            dual_c, conflict_c, pick_left_c;

  // Transfer mapper looks at the source while idle, the latched destination after.
  assign xid_c = (state_q == S_IDLE) ? xfer_src : xdst_q;

  regfile_map #(.NREG(NREG)) u_map_l (
    .id(id_l), .bank(bank_q), .sel_c(sel_l_c),
    .left_c(left_l_c), .right_c(right_l_c), .bad_c(bad_l_c)
  );
  regfile_map #(.NREG(NREG)) u_map_r (
    .id(id_r), .bank(bank_q), .sel_c(sel_r_c),
    .left_c(left_r_c), .right_c(right_r_c), .bad_c(bad_r_c)
  );
  regfile_map #(.NREG(NREG)) u_map_x (
    .id(xid_c), .bank(bank_q), .sel_c(sel_x_c),
    .left_c(left_x_c), .right_c(right_x_c), .bad_c(bad_x_c)
  );

  // Pointer 0 favours left on conflict; lone requesters always win.
  assign dual_c      = req_l & req_r & left_l_c & right_r_c;
  assign conflict_c  = req_l & req_r;
  assign pick_left_c = req_l & (~req_r | ~rr_q);

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    rr_d        = rr_q;
    xdst_d      = xdst_q;
    regsel_d    = '0;
    pc_wr_d     = 1'b0;
    reg_wr_d    = 1'b0;
    r_p_d       = 1'b0;
    gnt_l_d     = 1'b0;
    gnt_r_d     = 1'b0;
    xfer_done_d = 1'b0;
    exch_ack_d  = 1'b0;
    id_err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (exch != EXCH_NONE) begin
          exch_ack_d = 1'b1;
          case (exch)
            EXCH_AF:  bank_d.af_bank  = ~bank_q.af_bank;
            EXCH_EXX: bank_d.exx_bank = ~bank_q.exx_bank;
            default:  bank_d.dehl_swap[bank_q.exx_bank] = ~bank_q.dehl_swap[bank_q.exx_bank];
          endcase
        end else if (xfer_req) begin
          xdst_d   = xfer_dst;
          regsel_d = sel_x_c;
          r_p_d    = 1'b1;
          state_d  = S_XFER_RD;
        end else if (dual_c) begin
          gnt_l_d  = 1'b1;
          gnt_r_d  = 1'b1;
          regsel_d = sel_l_c | sel_r_c;
          pc_wr_d  = wr_l;
          reg_wr_d = wr_r;
        end else if (req_l | req_r) begin
          if (conflict_c) rr_d = ~rr_q;
          if (pick_left_c) begin
            gnt_l_d  = 1'b1;
            regsel_d = sel_l_c;
            pc_wr_d  = wr_l & left_l_c;
            reg_wr_d = wr_l & right_l_c;
            r_p_d    = right_l_c;
            id_err_d = bad_l_c;
          end else begin
            gnt_r_d  = 1'b1;
            regsel_d = sel_r_c;
            pc_wr_d  = wr_r & left_r_c;
            reg_wr_d = wr_r & right_r_c;
            r_p_d    = left_r_c;
            id_err_d = bad_r_c;
          end
        end
      end
      S_XFER_RD: begin
        regsel_d    = sel_x_c;
        r_p_d       = 1'b1;
        pc_wr_d     = left_x_c;
        reg_wr_d    = right_x_c & ~bad_x_c;
        xfer_done_d = 1'b1;
        state_d     = S_XFER_WR;
      end
      S_XFER_WR: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge eclk or negedge erst_n) begin
    if (!erst_n) begin
      state_q   <= S_IDLE;
      bank_q    <= '0;
      rr_q      <= 1'b0;
      xdst_q    <= '0;
      regsel    <= '0;
      pc_wr     <= 1'b0;
      reg_wr    <= 1'b0;
      r_p       <= 1'b0;
      gnt_l     <= 1'b0;
      gnt_r     <= 1'b0;
      xfer_done <= 1'b0;
      exch_ack  <= 1'b0;
      id_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      rr_q      <= rr_d;
      xdst_q    <= xdst_d;
      regsel    <= regsel_d;
      pc_wr     <= pc_wr_d;
      reg_wr    <= reg_wr_d;
      r_p       <= r_p_d;
      gnt_l     <= gnt_l_d;
      gnt_r     <= gnt_r_d;
      xfer_done <= xfer_done_d;
      exch_ack  <= exch_ack_d;
      id_err    <= id_err_d;
    end
  end

endmodule

// File: tb/tb_regfile_scheduler.sv
// Self-checking bench for regfile_scheduler: directed vector table, reset
// corner sequence, then random traffic against a behavioural model.
module tb_regfile_scheduler;

  logic        eclk = 1'b0;
  logic        erst_n;
  logic        req_l, wr_l, req_r, wr_r, xfer_req;
  logic [3:0]  id_l, id_r, xfer_src, xfer_dst;
  logic [1:0]  exch;
  logic [13:0] regsel;
  logic        pc_wr, reg_wr, r_p, gnt_l, gnt_r, xfer_done, exch_ack, id_err;

  always #5 eclk = ~eclk;

  regfile_scheduler #(.NREG(14)) dut (
    .eclk(eclk), .erst_n(erst_n),
    .req_l(req_l), .id_l(id_l), .wr_l(wr_l),
    .req_r(req_r), .id_r(id_r), .wr_r(wr_r),
    .xfer_req(xfer_req), .xfer_src(xfer_src), .xfer_dst(xfer_dst),
    .exch(exch), .regsel(regsel), .pc_wr(pc_wr), .reg_wr(reg_wr), .r_p(r_p),
    .gnt_l(gnt_l), .gnt_r(gnt_r), .xfer_done(xfer_done),
    .exch_ack(exch_ack), .id_err(id_err)
  );

  typedef struct packed {
    logic       req_l; logic [3:0] id_l; logic wr_l;
    logic       req_r; logic [3:0] id_r; logic wr_r;
    logic       xfer_req; logic [3:0] xsrc; logic [3:0] xdst;
    logic [1:0] exch;
  } in_t;

  typedef struct packed {
    logic [13:0] regsel;
    logic pc_wr, reg_wr, r_p, gnt_l, gnt_r, xfer_done, exch_ack, id_err;
  } out_t;

  typedef struct { in_t stim; out_t want; } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Behavioural model state
  bit   m_af, m_exx, m_rr;
  bit [1:0] m_swap;
  int   m_phase, m_xdst;

  function automatic in_t rq(bit rl, int il, bit wl, bit rr, int ir, bit wr);
    in_t v = '0;
    v.req_l = rl; v.id_l = 4'(il); v.wr_l = wl;
    v.req_r = rr; v.id_r = 4'(ir); v.wr_r = wr;
    return v;
  endfunction

  function automatic in_t xf(int s, int d);
    in_t v = '0;
    v.xfer_req = 1'b1; v.xsrc = 4'(s); v.xdst = 4'(d);
    return v;
  endfunction

  function automatic in_t ex(int e);
    in_t v = '0;
    v.exch = 2'(e);
    return v;
  endfunction

  function automatic out_t o(int sel, bit pcw, bit rw, bit rp, bit gl, bit gr,
                             bit xd, bit ack, bit err);
    out_t r;
    r.regsel = 14'(sel); r.pc_wr = pcw; r.reg_wr = rw; r.r_p = rp;
    r.gnt_l = gl; r.gnt_r = gr; r.xfer_done = xd; r.exch_ack = ack; r.id_err = err;
    return r;
  endfunction

  function automatic void add(in_t s, out_t w);
    vec_t t;
    t.stim = s; t.want = w;
    vecs.push_back(t);
  endfunction

  task automatic drive(input in_t v);
    req_l = v.req_l; id_l = v.id_l; wr_l = v.wr_l;
    req_r = v.req_r; id_r = v.id_r; wr_r = v.wr_r;
    xfer_req = v.xfer_req; xfer_src = v.xsrc; xfer_dst = v.xdst;
    exch = v.exch;
  endtask

  task automatic check(input string name, input out_t want);
    out_t act;
    act = o(int'(regsel), pc_wr, reg_wr, r_p, gnt_l, gnt_r, xfer_done, exch_ack, id_err);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: actual regsel=%h flags=%b, expected regsel=%h flags=%b (pc_wr reg_wr r_p gnt_l gnt_r xfer_done exch_ack id_err)",
               name, act.regsel, act[7:0], want.regsel, want[7:0]);
    end
  endtask

  task automatic cyc(input in_t v, input out_t want, input string name);
    drive(v);
    @(posedge eclk); #1;
    check(name, want);
  endtask

  // Segment: 0 left, 1 right, 2 invalid id
  function automatic int seg(int id);
    return (id < 2) ? 0 : (id < 10) ? 1 : 2;
  endfunction

  function automatic int phys(int id);
    bit is_hl;
    if (id < 6) return id;
    if (id == 8) return m_exx ? 10 : 11;
    if (id == 9) return m_af ? 12 : 13;
    if (id > 9) return -1;
    is_hl = (id == 6) ^ m_swap[m_exx];
    if (is_hl) return m_exx ? 6 : 7;
    return m_exx ? 8 : 9;
  endfunction

  function automatic logic [13:0] mask(int p);
    logic [13:0] one = 14'd1;
    return (p < 0) ? 14'd0 : (one << p);
  endfunction

  task automatic model_reset();
    m_af = 0; m_exx = 0; m_rr = 0; m_swap = 2'b00; m_phase = 0; m_xdst = 0;
  endtask

  task automatic model_step(input in_t v, output out_t e);
    int  id, s;
    bit  take_l, w;
    e = '0;
    if (m_phase == 1) begin
      e.regsel = mask(phys(m_xdst)); e.r_p = 1'b1;
      e.pc_wr = (seg(m_xdst) == 0); e.reg_wr = (seg(m_xdst) == 1);
      e.xfer_done = 1'b1; m_phase = 2;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else if (v.exch != 2'b00) begin
      e.exch_ack = 1'b1;
      if (v.exch == 2'b01) m_af = !m_af;
      else if (v.exch == 2'b10) m_exx = !m_exx;
      else m_swap[m_exx] = !m_swap[m_exx];
    end else if (v.xfer_req) begin
      e.regsel = mask(phys(int'(v.xsrc))); e.r_p = 1'b1;
      m_xdst = int'(v.xdst); m_phase = 1;
    end else if (v.req_l && v.req_r && seg(int'(v.id_l)) == 0 && seg(int'(v.id_r)) == 1) begin
      e.gnt_l = 1'b1; e.gnt_r = 1'b1;
      e.regsel = mask(phys(int'(v.id_l))) | mask(phys(int'(v.id_r)));
      e.pc_wr = v.wr_l; e.reg_wr = v.wr_r;
    end else if (v.req_l || v.req_r) begin
      take_l = v.req_l && (!v.req_r || !m_rr);
      if (v.req_l && v.req_r) m_rr = !m_rr;
      id = take_l ? int'(v.id_l) : int'(v.id_r);
      w  = take_l ? v.wr_l : v.wr_r;
      s  = seg(id);
      e.gnt_l = take_l; e.gnt_r = !take_l;
      e.regsel = mask(phys(id));
      e.pc_wr = w && s == 0; e.reg_wr = w && s == 1;
      e.id_err = (s == 2);
      e.r_p = (s != 2) && (take_l ? (s == 1) : (s == 0));
    end
  endtask

  initial begin
    in_t  v;
    out_t e;
    bit   pl, pr, wl, wr;
    int   il, ir, r;

    // Directed vectors; each row's expectation is the output one cycle later.
    add(rq(0,0,0,0,0,0),  o(0,     0,0,0,0,0,0,0,0));
    add(rq(1,0,0,1,8,1),  o('h0801,0,1,0,1,1,0,0,0));
    add(rq(1,3,0,1,2,0),  o('h0008,0,0,1,1,0,0,0,0));
    add(rq(0,0,0,1,2,0),  o('h0004,0,0,0,0,1,0,0,0));
    add(rq(1,1,1,1,1,1),  o('h0002,1,0,1,0,1,0,0,0));
    add(rq(1,1,1,0,0,0),  o('h0002,1,0,0,1,0,0,0,0));
    add(xf(6,3) | rq(1,0,0,0,0,0), o('h0080,0,0,1,0,0,0,0,0));
    add(ex(2) | rq(1,0,0,0,0,0),   o('h0008,0,1,1,0,0,1,0,0));
    add(ex(2) | rq(1,0,0,0,0,0),   o(0,     0,0,0,0,0,0,0,0));
    add(rq(1,0,0,0,0,0),  o('h0001,0,0,0,1,0,0,0,0));
    add(xf(3,0),          o('h0008,0,0,1,0,0,0,0,0));
    add(rq(0,0,0,0,0,0),  o('h0001,1,0,1,0,0,1,0,0));
    add(rq(0,0,0,0,0,0),  o(0,     0,0,0,0,0,0,0,0));
    add(ex(2),            o(0,     0,0,0,0,0,0,1,0));
    add(rq(0,0,0,1,6,0),  o('h0040,0,0,0,0,1,0,0,0));
    add(ex(2),            o(0,     0,0,0,0,0,0,1,0));
    add(ex(3),            o(0,     0,0,0,0,0,0,1,0));
    add(rq(0,0,0,1,7,0),  o('h0080,0,0,0,0,1,0,0,0));
    add(rq(0,0,0,1,6,1),  o('h0200,0,1,0,0,1,0,0,0));
    add(ex(1),            o(0,     0,0,0,0,0,0,1,0));
    add(rq(1,9,1,0,0,0),  o('h1000,0,1,1,1,0,0,0,0));
    add(rq(1,12,0,0,0,0), o(0,     0,0,0,1,0,0,0,1));
    add(rq(0,0,0,1,15,1), o(0,     0,0,0,0,1,0,0,1));
    add(ex(2),            o(0,     0,0,0,0,0,0,1,0));
    add(rq(0,0,0,1,6,0),  o('h0040,0,0,0,0,1,0,0,0));
    add(rq(0,0,0,1,9,0),  o('h1000,0,0,0,0,1,0,0,0));

    erst_n = 1'b0;
    drive('0);
    #12;
    check("reset_outputs", o(0,0,0,0,0,0,0,0,0));
    @(negedge eclk);
    erst_n = 1'b1;

    foreach (vecs[i]) cyc(vecs[i].stim, vecs[i].want, $sformatf("vec%0d", i));

    // Reset landing in the middle of a copy; banks now af=1, exx=1, swap[0]=1.
    cyc(rq(1,3,0,1,2,0), o('h0008,0,0,1,1,0,0,0,0), "pre_rst_conflict");
    cyc(xf(6,3),         o('h0040,0,0,1,0,0,0,0,0), "xfer_rd_bank1");
    drive('0);
    #2 erst_n = 1'b0;
    #1 check("rst_async_clear", o(0,0,0,0,0,0,0,0,0));
    @(posedge eclk); #1;
    check("rst_held", o(0,0,0,0,0,0,0,0,0));
    @(negedge eclk);
    erst_n = 1'b1;
    @(posedge eclk); #1;
    check("no_xfer_wr_after_rst", o(0,0,0,0,0,0,0,0,0));
    cyc(rq(1,3,0,1,2,0), o('h0008,0,0,1,1,0,0,0,0), "rr_ptr_reset");
    cyc(rq(0,0,0,1,2,0), o('h0004,0,0,0,0,1,0,0,0), "rr_second");
    cyc(rq(0,0,0,1,6,0), o('h0080,0,0,0,0,1,0,0,0), "exx_reset");
    cyc(rq(0,0,0,1,9,0), o('h2000,0,0,0,0,1,0,0,0), "af_reset");

    // Random traffic from protocol-abiding requesters against the model.
    drive('0);
    erst_n = 1'b0;
    @(posedge eclk);
    @(negedge eclk);
    erst_n = 1'b1;
    model_reset();
    pl = 0; pr = 0; il = 0; ir = 0; wl = 0; wr = 0;
    for (int c = 0; c < 600; c++) begin
      if (!pl && $urandom_range(0, 2) == 0) begin
        pl = 1; il = int'($urandom_range(0, 11)); wl = 1'($urandom_range(0, 1));
      end
      if (!pr && $urandom_range(0, 2) == 0) begin
        pr = 1; ir = int'($urandom_range(0, 11)); wr = 1'($urandom_range(0, 1));
      end
      v = rq(pl, il, wl, pr, ir, wr);
      r = int'($urandom_range(0, 9));
      if (r == 0) v = v | ex(int'($urandom_range(1, 3)));
      else if (r == 1) v = v | xf(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
      drive(v);
      model_step(v, e);
      @(posedge eclk); #1;
      check($sformatf("rand%0d", c), e);
      if (e.gnt_l) pl = 0;
      if (e.gnt_r) pr = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_scheduler.md
REGFILE_SCHEDULER -- requirements
Module: regfile_scheduler

Interface
REQ-001 SHALL have a parameter, one per line: name, default, meaning.
  - NREG, 14, number of physical register selects driven (fixed bit map below).
REQ-002 SHALL have these ports, one per line: name, direction, width, meaning.
  - eclk  in  1  single system clock; all state on rising edge.
  - erst_n  in  1  asynchronous, active-low reset.
  - req_l  in  1  left (address-side) requester valid; held until gnt_l.
  - id_l  in  4  left logical register id.
  - wr_l  in  1  left op is write (1) or read (0).
  - req_r  in  1  right (ALU-side) requester valid; held until gnt_r.
  - id_r  in  4  right logical register id.
  - wr_r  in  1  right op is write (1) or read (0).
  - xfer_req  in  1  register-to-register copy request.
  - xfer_src  in  4  copy source logical id.
  - xfer_dst  in  4  copy destination logical id.
  - exch  in  2  exchange command: 00 none, 01 EX AF, 10 EXX, 11 EX DE,HL.
  - regsel  out  14  one-hot-per-segment physical selects.
  - pc_wr  out  1  left-segment write strobe.
  - reg_wr  out  1  right-segment write strobe.
  - r_p  out  1  join left and right buses.
  - gnt_l, gnt_r, xfer_done, exch_ack  out  1 each  one-cycle completion pulses.
  - id_err  out  1  one-cycle pulse on granted request with id 10..15.
REQ-003 SHALL decode logical ids as: 0 PC, 1 IR, 2 WZ, 3 SP, 4 IY, 5 IX, 6 HL, 7 DE, 8 BC, 9 AF.
REQ-004 SHALL map physical regsel bits as: 0 PC, 1 IR, 2 WZ, 3 SP, 4 IY, 5 IX, 6 HL1, 7 HL0, 8 DE1, 9 DE0, 10 BC1, 11 BC0, 12 AF1, 13 AF0; bits 1:0 are the left segment, bits 13:2 the right segment.

Function
REQ-005 SHALL hold bank state af_bank, exx_bank, and dehl_swap[1:0] (one bit per EXX bank); AF maps to AF{af_bank}, BC to BC{exx_bank}; HL/DE map to HL/DE{exx_bank}, swapped when dehl_swap[exx_bank]=1.
REQ-006 SHALL use state machine IDLE, XFER_RD, XFER_WR; all outputs are registered, asserted the cycle after the request is sampled.
REQ-007 In IDLE, exch!=00 SHALL have top priority: toggle the addressed bank bit, pulse exch_ack, and drive no selects that cycle.
REQ-008 Otherwise, in IDLE, xfer_req SHALL take priority over req_l/req_r: cycle 1 (XFER_RD) selects source with r_p=1 and no write strobe; cycle 2 (XFER_WR) selects destination with r_p=1, pc_wr=1 if destination is PC/IR, else reg_wr=1; xfer_done pulses in XFER_WR; return to IDLE.
REQ-009 In IDLE, if req_l targets the left segment and req_r the right segment, both SHALL be granted in the same cycle with r_p=0.
REQ-010 Any single grant crossing segments (left requester to right register, or right requester to left register) SHALL drive r_p=1.
REQ-011 On conflict, exactly one requester SHALL be granted, chosen by a round-robin pointer that flips to the other side after each conflict grant; non-conflicting grants leave the pointer unchanged.
REQ-012 A write grant SHALL assert pc_wr for left-segment targets and reg_wr for right-segment targets; read grants assert neither.
REQ-013 An id of 10..15 SHALL be granted with no regsel bit, no strobe, and an id_err pulse.
REQ-014 Exchange commands arriving outside IDLE SHALL be ignored (no ack); the issuer re-presents them.
REQ-015 With no activity, regsel, strobes, and r_p SHALL be 0.

Reset
REQ-016 erst_n low SHALL immediately force: state IDLE, all bank bits 0, round-robin pointer to left, regsel 0, and all strobes and pulses 0, including mid-transfer.

Structure
REQ-017 Logical id constants, physical bit indices, exch encodings, and state encoding SHALL live in a shared package regfile_pkg.
REQ-018 Logical-to-physical mapping SHALL be one combinational sub-module regfile_map, instanced three times (left, right, transfer).

Verification
REQ-019 After reset: req_l id 0 read plus req_r id 8 write -> next cycle gnt_l=gnt_r=1, regsel=0x0801, reg_wr=1, pc_wr=0, r_p=0.
REQ-020 req_l id 3 plus req_r id 2 together -> gnt_l first (regsel=0x0008, r_p=1); next cycle gnt_r (regsel=0x0004, r_p=0).
REQ-021 exch=10 then req_r id 6 read -> exch_ack, then regsel=0x0040.
REQ-022 exch=11 in bank 0, then req_r id 7 read -> regsel=0x0080 (HL0).
REQ-023 xfer 6->3 -> regsel=0x0080 with r_p=1, then regsel=0x0008 with reg_wr=1 and xfer_done=1.
REQ-024 erst_n low during XFER_RD -> all outputs 0 immediately; no XFER_WR follows.
